// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the debug/dump port.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution instead of CPU priority with a starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              halted,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  owner_t            rd_owner;
  logic              cpu_grant;
  logic              dbg_grant;
  logic [DATA_W-1:0] cpu_rdata_hold;
  logic [DATA_W-1:0] dbg_rdata_hold;

`ifdef DMEM_ARB_RR_EN
  logic last_dbg;  // 1: debug owned the most recent grant

  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      if (halted) begin
        dbg_grant = dbg_req;
        cpu_grant = cpu_req & ~dbg_req;
      end else if (cpu_req && dbg_req) begin
        dbg_grant = ~last_dbg;
        cpu_grant = last_dbg;
      end else begin
        dbg_grant = dbg_req;
        cpu_grant = cpu_req;
      end
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      last_dbg <= 1'b1;
    end else if (dbg_grant) begin
      last_dbg <= 1'b1;
    end else if (cpu_grant) begin
      last_dbg <= 1'b0;
    end
  end
`else
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      if (halted) begin
        dbg_grant = dbg_req;
      end else begin
        dbg_grant = dbg_req & ((wait_cnt == WAIT_LIMIT) | ~cpu_req);
      end
      cpu_grant = cpu_req & ~dbg_grant;
    end
  end

  // Counts consecutive cycles a pending debug request lost to the CPU.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`endif

  assign cpu_stall = cpu_req & ~cpu_grant & ~reset;
  assign dbg_gnt   = dbg_grant;

  always_comb begin
    mem_en    = cpu_grant | dbg_grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_grant) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_grant) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Tag each granted read so the returning data goes to the right port.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else if (dbg_grant && !dbg_we) begin
      rd_owner <= OWN_DBG;
    end else if (cpu_grant && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cpu_rdata_hold <= '0;
      dbg_rdata_hold <= '0;
    end else begin
      if (rd_owner == OWN_CPU) cpu_rdata_hold <= mem_rdata;
      if (rd_owner == OWN_DBG) dbg_rdata_hold <= mem_rdata;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dbg_rvalid = (rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_hold;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 8192x32 data memory between the pipeline MEM stage (CPU port) and a debug/dump port used for preload and post-run memory readout. The CPU has priority. A starvation counter guarantees the debug port a slot. When the core is halted, the debug port receives every cycle. Sits between the MEM stage, the debug host and the D-memory array.

Parameters:
ADDR_W, 13, word address width (8192 words)
DATA_W, 32, data word width
MAX_WAIT, 4, consecutive cycles a pending debug request may lose before it is forced through (1..15)

Ports:
clk1  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
halted  in  1  core halted flag; debug gets unconditional priority
cpu_req  in  1  CPU memory access request
cpu_we  in  1  CPU write enable (qualified by cpu_req)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request not accepted this cycle; MEM stage must hold
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (one cycle)
dbg_req  in  1  debug access request
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug request accepted this cycle
dbg_rdata  out  DATA_W  debug read data
dbg_rvalid  out  1  dbg_rdata valid (one cycle)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset: all outputs 0; wait_cnt=0; rd_owner=NONE; any in-flight read is discarded, so no rvalid follows reset.
- Grant is combinational each cycle; exactly one owner or none.
  - halted=1: dbg_req wins.
  - halted=0: dbg wins if dbg_req and (wait_cnt==MAX_WAIT or !cpu_req); otherwise cpu_req wins.
- cpu_stall = cpu_req & !cpu_grant. dbg_gnt = dbg_grant.
- Requesters hold req and all qualifiers stable until accepted. Inputs changing while a request is stalled are undefined use.
- mem_* is driven from the granted port and is 0 when there is no grant.
- wait_cnt:
  - clears on any debug grant or when dbg_req=0;
  - increments when dbg_req=1 and the debug port is not granted;
  - saturates at MAX_WAIT.
- Read return: on a granted read, rd_owner register = CPU or DBG. Next cycle the owner's rvalid=1 and its rdata = mem_rdata. The other port's rvalid=0. rdata ports hold the last value between reads.
- Writes complete in the grant cycle; no rvalid is produced.
- Back-to-back grants every cycle are allowed, so throughput is 1 access/cycle.
- Same-address write then read in consecutive cycles returns the new data; this relies on the memory's write-first timing.
- Async reset asserted mid-stall: stall drops, and the requester must re-present after reset.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: the starvation counter is removed. When halted=0 and both ports request, grant alternates round-robin via a 1-bit last_owner register (reset = DBG, so CPU wins the first conflict). halted still forces debug priority.
- Undefined: fixed CPU priority with MAX_WAIT starvation guard, as above.

Test Plan:
1. Reset mid-read: debug read addr 0x0005 granted, reset pulsed the next cycle -> dbg_rvalid stays 0, all outputs 0.
2. CPU-only traffic: write 0x00000064 to addr 25, then read addr 25 -> cpu_stall=0 both cycles; cpu_rvalid=1 with cpu_rdata=0x00000064 one cycle after the read.
3. Starvation guard (MAX_WAIT=4): cpu_req held high continuously, dbg read addr 0x1FFF pending -> dbg_gnt after exactly 4 lost cycles; cpu_stall=1 in that cycle only; dbg_rvalid the next cycle.
4. Halted dump: halted=1, dbg reads addr 0..7 back-to-back while cpu_req=1 -> dbg_gnt every cycle, cpu_stall=1 throughout, dbg_rvalid for 8 consecutive cycles with the preloaded values in order.
5. DMEM_ARB_RR_EN: both ports request continuously for 6 cycles -> grants go CPU, DBG, CPU, DBG, CPU, DBG.
6. Ownership tagging: CPU read addr 3 followed by debug read addr 4 the next cycle -> cpu_rvalid then dbg_rvalid on successive cycles, never both high, each carrying its own address's data.
